count_capture_fifo: RTL and testbench



---
 rtl/count_capture_fifo.sv | 130 +++++++++++++
 tb/tb_count_capture_fifo.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_capture_fifo.sv
// count_capture_fifo: timestamps rising edges of an event strobe against a
// free-running counter and queues the snapshots in a small FIFO drained
// through a valid/ready interface.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   count_in     counter value to snapshot
//   evt_in       event strobe, captured on its rising edge
//   en           capture enable (events ignored while low)
//   clr_ovf      synchronous clear of the overflow sticky flag
//   out_data     head entry (oldest snapshot), read straight from storage
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts head when out_valid is high
//   level        occupied entries, 0..DEPTH
//   ovf          sticky: a capture was dropped because the FIFO was full
//
// Build option: define CAPTURE_SYNC_EN to insert a 2-flop synchroniser on
// evt_in (adds 2 cycles of capture latency, for asynchronous event sources).

module count_capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVLW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_in,
  input  logic             evt_in,
  input  logic             en,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVLW-1:0]  level,
  output logic             ovf
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             evt_s;
  logic             evt_q;
  logic             rise;
  logic             push_req;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;
  logic [LVLW-1:0]  level_nxt;
  logic [PTRW-1:0]  wptr;
  logic [PTRW-1:0]  rptr;
  logic [WIDTH-1:0] mem [DEPTH];

`ifdef CAPTURE_SYNC_EN
  logic sync1;
  logic sync2;

  // Synchroniser flops reset high so a strobe held through reset never fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= evt_in;
      sync2 <= sync1;
    end
  end

  assign evt_s = sync2;
`else
  assign evt_s = evt_in;
`endif

  // Edge-detector history; tracks regardless of en so a late enable cannot fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= 1'b1;
    end else begin
      evt_q <= evt_s;
    end
  end

  // Push/pop decisions; a push into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    rise      = evt_s & ~evt_q;
    push_req  = rise & en;
    pop       = out_valid & out_ready;
    full      = (level == LVLW'(DEPTH));
    push      = push_req & (~full | pop);
    drop      = push_req & full & ~pop;
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + LVLW'(1);
      2'b01:   level_nxt = level - LVLW'(1);
      default: level_nxt = level;
    endcase
  end

  // Occupancy, pointers and overflow flag; a dropped push beats clr_ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level     <= '0;
      out_valid <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      ovf       <= 1'b0;
    end else begin
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      if (push) wptr <= wptr + PTRW'(1);
      if (pop)  rptr <= rptr + PTRW'(1);
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  // Snapshot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= count_in;
    end
  end

  assign out_data = mem[rptr];

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo. Inputs change 1 time unit after a
// rising clock edge and outputs are checked at that same point.

module tb_count_capture_fifo;

`ifdef CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] count_in;
  logic       evt_in;
  logic       en;
  logic       clr_ovf;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       ovf;

  int vecs;
  int errs;

  count_capture_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_in  (count_in),
    .evt_in    (evt_in),
    .en        (en),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One event: rising edge of evt_in; count_in equals val only at the edge
  // that registers the push (LAT edges after the first high sample).
  task automatic pulse(input logic [7:0] val, input logic pop, input logic clr);
    for (int i = 0; i <= LAT; i++) begin
      evt_in = (i == 0);
      if (i == LAT) begin
        count_in  = val;
        out_ready = pop;
        clr_ovf   = clr;
      end else begin
        count_in  = ~val;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
      end
      step();
    end
    evt_in    = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    count_in  = ~val;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; evt_in = 1'b1; en = 1'b1; clr_ovf = 1'b0;
    out_ready = 1'b0; count_in = 8'h00;
    #2;
    vecs++;
    if (out_valid !== 1'b0 || level !== 3'd0 || ovf !== 1'b0 || out_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_values: valid=%b level=%0d ovf=%b data=%h, want 0 0 0 00",
               out_valid, level, ovf, out_data);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      count_in = 8'(c + 1);
      step();
      vecs++;
      if (out_valid !== 1'b0 || level !== 3'd0) begin
        errs++;
        $display("FAIL held_evt_no_push cycle %0d: valid=%b level=%0d, want 0 0",
                 c, out_valid, level);
      end
    end
    evt_in = 1'b0;
    step();
    pulse(8'h2A, 1'b0, 1'b0);
    vecs++;
    if (out_data !== 8'h2A || out_valid !== 1'b1 || level !== 3'd1) begin
      errs++;
      $display("FAIL first_capture: data=%h valid=%b level=%0d, want 2a 1 1",
               out_data, out_valid, level);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vecs++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errs++;
      $display("FAIL first_drain: valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

`ifdef CAPTURE_SYNC_EN
  task automatic test_sync_latency();
    evt_in = 1'b1; count_in = 8'h70;
    step();
    evt_in = 1'b0;
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL sync_edge_k: valid=%b, want 0", out_valid);
    end
    count_in = 8'h71;
    step();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL sync_edge_k1: valid=%b, want 0", out_valid);
    end
    count_in = 8'h72;
    step();
    vecs++;
    if (out_valid !== 1'b1 || out_data !== 8'h72) begin
      errs++;
      $display("FAIL sync_edge_k2: valid=%b data=%h, want 1 72", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
  endtask
`endif

  task automatic test_overflow();
    logic [7:0] vals [5];
    vals = '{8'h10, 8'h12, 8'h14, 8'h16, 8'h18};
    for (int i = 0; i < 5; i++) pulse(vals[i], 1'b0, 1'b0);
    vecs++;
    if (level !== 3'd4 || ovf !== 1'b1 || out_data !== 8'h10) begin
      errs++;
      $display("FAIL overflow_state: level=%0d ovf=%b head=%h, want 4 1 10",
               level, ovf, out_data);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        errs++;
        $display("FAIL overflow_drain[%0d]: valid=%b data=%h, want 1 %h",
                 i, out_valid, out_data, vals[i]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    vecs++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL overflow_empty: level=%0d valid=%b, want 0 0", level, out_valid);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    vecs++;
    if (ovf !== 1'b0) begin
      errs++;
      $display("FAIL ovf_clear: ovf=%b, want 0", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] vals [4];
    for (int i = 0; i < 4; i++) pulse(8'(8'h20 + i), 1'b0, 1'b0);
    pulse(8'h24, 1'b1, 1'b0);
    vecs++;
    if (level !== 3'd4 || ovf !== 1'b0 || out_data !== 8'h21) begin
      errs++;
      $display("FAIL full_push_pop: level=%0d ovf=%b head=%h, want 4 0 21",
               level, ovf, out_data);
    end
    // Dropped push with clr_ovf on the same edge: the set must win.
    pulse(8'h30, 1'b0, 1'b1);
    vecs++;
    if (ovf !== 1'b1 || level !== 3'd4 || out_data !== 8'h21) begin
      errs++;
      $display("FAIL clr_vs_drop: ovf=%b level=%0d head=%h, want 1 4 21",
               ovf, level, out_data);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    vecs++;
    if (ovf !== 1'b0) begin
      errs++;
      $display("FAIL clr_alone: ovf=%b, want 0", ovf);
    end
    vals = '{8'h21, 8'h22, 8'h23, 8'h24};
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        errs++;
        $display("FAIL full_drain[%0d]: valid=%b data=%h, want 1 %h",
                 i, out_valid, out_data, vals[i]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    vecs++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errs++;
      $display("FAIL full_empty: valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  task automatic test_enable_and_wrap();
    en = 1'b0;
    pulse(8'h40, 1'b0, 1'b0);
    pulse(8'h41, 1'b0, 1'b0);
    pulse(8'h42, 1'b0, 1'b0);
    vecs++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL en_low_discard: level=%0d valid=%b, want 0 0", level, out_valid);
    end
    evt_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
    en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    vecs++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL en_rise_while_high: level=%0d valid=%b, want 0 0", level, out_valid);
    end
    evt_in = 1'b0;
    step();
    pulse(8'hFF, 1'b0, 1'b0);
    vecs++;
    if (out_data !== 8'hFF || level !== 3'd1) begin
      errs++;
      $display("FAIL wrap_first: data=%h level=%0d, want ff 1", out_data, level);
    end
    pulse(8'h03, 1'b0, 1'b0);
    vecs++;
    if (level !== 3'd2 || out_data !== 8'hFF) begin
      errs++;
      $display("FAIL wrap_level: level=%0d head=%h, want 2 ff", level, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vecs++;
    if (out_data !== 8'h03 || level !== 3'd1) begin
      errs++;
      $display("FAIL wrap_second: data=%h level=%0d, want 03 1", out_data, level);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    pulse(8'h50, 1'b0, 1'b0);
    pulse(8'h51, 1'b0, 1'b0);
    pulse(8'h52, 1'b0, 1'b0);
    vecs++;
    if (level !== 3'd3 || out_data !== 8'h50) begin
      errs++;
      $display("FAIL pre_reset_fill: level=%0d head=%h, want 3 50", level, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 8'h00) begin
      errs++;
      $display("FAIL async_reset: valid=%b level=%0d data=%h, want 0 0 00",
               out_valid, level, out_data);
    end
    #2;
    rst_n = 1'b1;
    step();
    step();
    vecs++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errs++;
      $display("FAIL post_reset_idle: valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
`ifdef CAPTURE_SYNC_EN
    test_sync_latency();
`endif
    test_overflow();
    test_full_push_pop();
    test_enable_and_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
